// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment scanner with per-frame input snapshot and blank-interval anti-ghosting.
// Optional leading-zero blanking of the ans_h digit is enabled by defining SEG_LZB_EN.
module seg_scan4 #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num1_seg,
    input  logic [3:0] num2_seg,
    input  logic [3:0] ans_h,
    input  logic [3:0] ans_l,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [3:0]    s0, s1, s2, s3;

    logic          tick;
    logic          wrap;
    logic          blank;
    logic [3:0]    cur;
    logic [3:0]    an_drive;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0:    r = 7'b1000000;
            4'h1:    r = 7'b1111001;
            4'h2:    r = 7'b0100100;
            4'h3:    r = 7'b0110000;
            4'h4:    r = 7'b0011001;
            4'h5:    r = 7'b0010010;
            4'h6:    r = 7'b0000010;
            4'h7:    r = 7'b1111000;
            4'h8:    r = 7'b0000000;
            4'h9:    r = 7'b0010000;
            4'hA:    r = 7'b0001000;
            4'hB:    r = 7'b0000011;
            4'hC:    r = 7'b1000110;
            4'hD:    r = 7'b0100001;
            4'hE:    r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    always_comb begin
        tick = (cnt == LAST);
        wrap = tick && (dig == 2'd3);

        cur      = s0;
        an_drive = 4'b0111;
        case (dig)
            2'd0: begin cur = s0; an_drive = 4'b0111; end
            2'd1: begin cur = s1; an_drive = 4'b1011; end
            2'd2: begin cur = s2; an_drive = 4'b1101; end
            default: begin cur = s3; an_drive = 4'b1110; end
        endcase

        blank = (cnt < BLANK_END);
`ifdef SEG_LZB_EN
        // A zero high result nibble keeps its whole slot dark; slot timing is unaffected.
        if ((dig == 2'd2) && (s2 == 4'h0)) begin
            blank = 1'b1;
        end
`endif

        an_next  = blank ? '1 : an_drive;
        seg_next = blank ? '1 : hex7(cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dig <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                dig <= dig + 2'd1;
            end
        end
    end

    // All four nibbles load together, only at the frame wrap, so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else if (wrap && load) begin
            s0 <= num1_seg;
            s1 <= num2_seg;
            s2 <= ans_h;
            s3 <= ans_l;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= '1;
            seg   <= '1;
            frame <= 1'b0;
        end else begin
            an    <= an_next;
            seg   <= seg_next;
            frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 (DIV=8, BLANK=2): time-based reference model checked every cycle,
// plus hand-computed literal expectations at chosen edges.
module tb_seg_scan4;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRM   = 4 * DIV;

    logic       clk;
    logic       rst;
    logic [3:0] num1_seg, num2_seg, ans_h, ans_l;
    logic       load;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;

    int vectors;
    int miscompares;

    seg_scan4 #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .num1_seg (num1_seg),
        .num2_seg (num2_seg),
        .ans_h    (ans_h),
        .ans_l    (ans_l),
        .load     (load),
        .an       (an),
        .seg      (seg),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference: t = clock edges since reset release; position in the scan is pure arithmetic on t.
    int         t;
    logic [3:0] snap [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_frame;
    logic       started;

    always @(posedge clk) begin
        int c, d;
        logic blk;
        if (rst) begin
            t = 0;
            for (int i = 0; i < 4; i++) snap[i] = 4'h0;
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_frame = 1'b0;
        end else begin
            c = t % DIV;
            d = (t / DIV) % 4;
            exp_frame = ((t % FRM) == FRM - 1);
            blk = (c < BLANK);
`ifdef SEG_LZB_EN
            if (d == 2 && snap[2] == 4'h0) blk = 1'b1;
`endif
            if (blk) begin
                exp_an = 4'b1111; exp_seg = 7'b1111111;
            end else begin
                exp_an  = 4'b1111 & ~(4'b0001 << (3 - d));
                exp_seg = HEX[snap[d]];
            end
            if (exp_frame && load) begin
                snap[0] = num1_seg; snap[1] = num2_seg; snap[2] = ans_h; snap[3] = ans_l;
            end
            t = t + 1;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        if (started) begin
            ea = rst ? 4'b1111    : exp_an;
            es = rst ? 7'b1111111 : exp_seg;
            ef = rst ? 1'b0       : exp_frame;
            vectors++;
            if (an !== ea) begin
                miscompares++;
                $display("FAIL model_an t=%0d got=%b want=%b", t, an, ea);
            end
            vectors++;
            if (seg !== es) begin
                miscompares++;
                $display("FAIL model_seg t=%0d got=%b want=%b", t, seg, es);
            end
            vectors++;
            if (frame !== ef) begin
                miscompares++;
                $display("FAIL model_frame t=%0d got=%b want=%b", t, frame, ef);
            end
            vectors++;
            if ($countones(~an) > 1) begin
                miscompares++;
                $display("FAIL one_digit t=%0d got=%b want=at most one low", t, an);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] a, input logic [6:0] s,
                       input logic f, input logic [3:0] ea, input logic [6:0] es, input logic ef);
        vectors++;
        if (a !== ea || s !== es || f !== ef) begin
            miscompares++;
            $display("FAIL %s t=%0d got an=%b seg=%b frame=%b want an=%b seg=%b frame=%b",
                     name, t, a, s, f, ea, es, ef);
        end
    endtask

    // Leaves time 1 unit after the posedge that completes edge n.
    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (t < n && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (t != n) begin
            miscompares++;
            $display("FAIL goto_edge got=%0d want=%0d", t, n);
        end
    endtask

    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic l);
        num1_seg = a; num2_seg = b; ans_h = c; ans_l = d; load = l;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; started = 1'b0; t = 0;
        rst = 1'b1;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        @(posedge clk); #1;
        chk("reset_hold", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;

        goto(1);  chk("blank_e1", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
        goto(2);  chk("blank_e2", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
        goto(3);  chk("first_an3", an, seg, frame, 4'b0111, 7'b1000000, 1'b0);
        goto(11); chk("first_an2", an, seg, frame, 4'b1011, 7'b1000000, 1'b0);
        goto(31); chk("pre_frame", an, seg, frame, 4'b1110, 7'b1000000, 1'b0);
        goto(32); chk("frame_pulse", an, seg, frame, 4'b1110, 7'b1000000, 1'b1);
        goto(33); chk("frame_drop", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);

        set_in(4'h3, 4'h5, 4'h0, 4'h8, 1'b1);
        goto(64); chk("wrap64_old", an, seg, frame, 4'b1110, 7'b1000000, 1'b1);
        load = 1'b0;
        goto(67); chk("load_d0", an, seg, frame, 4'b0111, 7'b0110000, 1'b0);
        goto(75); chk("load_d1", an, seg, frame, 4'b1011, 7'b0010010, 1'b0);
        goto(83); chk("load_d2", an, seg, frame, 4'b1101, 7'b1000000, 1'b0);
        goto(91); chk("load_d3", an, seg, frame, 4'b1110, 7'b0000000, 1'b0);

        set_in(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
        goto(99);  chk("frozen_d0", an, seg, frame, 4'b0111, 7'b0110000, 1'b0);
        load = 1'b1;
        goto(129); load = 1'b0;
        goto(131); chk("f_d0", an, seg, frame, 4'b0111, 7'b0001110, 1'b0);
        goto(139); chk("f_d1", an, seg, frame, 4'b1011, 7'b0001110, 1'b0);

        // Load pulse between wraps must be ignored.
        set_in(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        goto(150); load = 1'b0;
        goto(155); chk("f_d3", an, seg, frame, 4'b1110, 7'b0001110, 1'b0);
        goto(163); chk("missed_load", an, seg, frame, 4'b0111, 7'b0001110, 1'b0);

        goto(179); chk("pre_rst_d2", an, seg, frame, 4'b1101, 7'b0001110, 1'b0);
        #1 rst = 1'b1;
        #1 chk("async_rst", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        goto(2); chk("restart_blank", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
        goto(3); chk("restart_an3", an, seg, frame, 4'b0111, 7'b1000000, 1'b0);

        set_in(4'h1, 4'h2, 4'h0, 4'h7, 1'b1);
        goto(33); load = 1'b0;
`ifdef SEG_LZB_EN
        goto(83); chk("lzb_zero", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
`else
        goto(83); chk("ansh_zero", an, seg, frame, 4'b1101, 7'b1000000, 1'b0);
`endif
        goto(91); chk("ansl_7", an, seg, frame, 4'b1110, 7'b1111000, 1'b0);
        set_in(4'h1, 4'h2, 4'h1, 4'h7, 1'b1);
        goto(97); load = 1'b0;
        goto(147); chk("ansh_one", an, seg, frame, 4'b1101, 7'b1111001, 1'b0);
        goto(160);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
